// File: rtl/la_arbiter_rr.sv
// Round-robin arbiter with a registered one-hot grant that sticks with its owner,
// plus an optional hold limit that forces hand-off while other requesters wait.
module la_arbiter_rr #(
   parameter int    N       = 2,
   parameter int    MAXHOLD = 0,
   parameter string PROP    = "DEFAULT",
   localparam int   IW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_id,
   output logic          busy
);

   localparam int CW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
   localparam logic [CW-1:0] HOLD_LAST = (MAXHOLD > 0) ? CW'(MAXHOLD - 1) : '0;
   localparam logic [CW-1:0] HOLD_SAT  = (MAXHOLD > 0) ? CW'(MAXHOLD) : '0;

   typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] id_q, id_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [N-1:0]  others;
   logic [N-1:0]  cand;
   logic          owner_req;
   logic          expire;
   logic          pick_vld;
   int            pick_idx;
   int            idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Rotating priority search: the lowest offset from the pointer wins.
   always_comb begin
      others    = req & ~gnt_q;
      owner_req = |(req & gnt_q);
      cand      = (state_q == IDLE) ? req : others;
      expire    = (MAXHOLD > 0) && en && (|others) && (cnt_q >= HOLD_LAST);
      pick_vld  = 1'b0;
      pick_idx  = 0;
      idx       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % N;
         if (cand[idx]) begin
            pick_vld = 1'b1;
            pick_idx = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (en && pick_vld) begin
               state_d = OWNED;
               gnt_d   = N'(1) << pick_idx;
               id_d    = IW'(pick_idx);
               ptr_d   = IW'((pick_idx + 1) % N);
            end
         end
         OWNED: begin
            // A release and a hold-limit expiry pick the next owner identically.
            if (!owner_req || expire) begin
               cnt_d = '0;
               if (en && pick_vld) begin
                  gnt_d = N'(1) << pick_idx;
                  id_d  = IW'(pick_idx);
                  ptr_d = IW'((pick_idx + 1) % N);
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  id_d    = '0;
               end
            end else if ((MAXHOLD > 0) && (cnt_q < HOLD_SAT)) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      gnt    = gnt_q;
      gnt_id = id_q;
      busy   = (state_q == OWNED) && (|gnt_q);
   end

endmodule

// File: tb/tb_la_arbiter_rr.sv
// Directed bench: one arbiter with unlimited hold, one with a 3-cycle hold limit.
module tb_la_arbiter_rr;

   logic       clk;
   logic       rst_a, en_a, busy_a;
   logic [3:0] req_a, gnt_a;
   logic [1:0] id_a;
   logic       rst_b, en_b, busy_b;
   logic [3:0] req_b, gnt_b;
   logic [1:0] id_b;

   int total;
   int bad;

   la_arbiter_rr #(.N(4), .MAXHOLD(0), .PROP("DEFAULT")) u_a (
      .clk(clk), .reset(rst_a), .en(en_a), .req(req_a),
      .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a)
   );

   la_arbiter_rr #(.N(4), .MAXHOLD(3), .PROP("DEFAULT")) u_b (
      .clk(clk), .reset(rst_b), .en(en_b), .req(req_b),
      .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] rr_req [5];
   logic [3:0] rr_gnt [5];
   logic [3:0] mh_gnt [9];

   initial begin
      total = 0;
      bad   = 0;
      rst_a = 1'b1; en_a = 1'b1; req_a = 4'b1111;
      rst_b = 1'b1; en_b = 1'b1; req_b = 4'b0000;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_gnt", gnt_a, 4'b0000);
         chk("rst_busy", busy_a, 1'b0);
      end
      rst_a = 1'b0;
      tick();
      chk("post_rst_gnt", gnt_a, 4'b0001);
      chk("post_rst_id", id_a, 2'd0);
      chk("post_rst_busy", busy_a, 1'b1);

      // Hold and handoff with no idle bubble
      req_a = 4'b1010;
      tick(); chk("hold1010_a", gnt_a, 4'b0010);
      tick(); chk("hold1010_b", gnt_a, 4'b0010);
      tick(); chk("hold1010_c", gnt_a, 4'b0010);
      chk("hold1010_id", id_a, 2'd1);
      req_a = 4'b1000;
      tick(); chk("handoff3", gnt_a, 4'b1000);
      chk("handoff3_id", id_a, 2'd3);
      req_a = 4'b0000;
      tick(); chk("release_idle", gnt_a, 4'b0000);
      chk("release_busy", busy_a, 1'b0);

      // Fair rotation: each owner drops for one cycle and re-raises
      rr_req = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
      rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
         req_a = rr_req[i];
         tick();
         chk("rr_gnt", gnt_a, rr_gnt[i]);
      end
      chk("rr_id_last", id_a, 2'd0);

      // Enable gating
      req_a = 4'b0000;
      tick(); chk("en_pre_idle", gnt_a, 4'b0000);
      en_a = 1'b0; req_a = 4'b0100;
      tick(); chk("en0_idle_a", gnt_a, 4'b0000);
      tick(); chk("en0_idle_b", gnt_a, 4'b0000);
      en_a = 1'b1;
      tick(); chk("en1_grant", gnt_a, 4'b0100);
      chk("en1_id", id_a, 2'd2);
      en_a = 1'b0;
      tick(); chk("en0_hold", gnt_a, 4'b0100);
      req_a = 4'b0110;
      tick(); chk("en0_hold_other", gnt_a, 4'b0100);
      req_a = 4'b0010;
      tick(); chk("en0_release", gnt_a, 4'b0000);

      // Reset mid-grant clears the pointer
      en_a = 1'b1; req_a = 4'b0100;
      tick(); chk("pre_rst_gnt", gnt_a, 4'b0100);
      rst_a = 1'b1;
      tick(); chk("midrst_gnt", gnt_a, 4'b0000);
      chk("midrst_busy", busy_a, 1'b0);
      rst_a = 1'b0; req_a = 4'b0110;
      tick(); chk("rst_ptr0", gnt_a, 4'b0010);
      chk("rst_ptr0_id", id_a, 2'd1);

      // Hold limit 3 with two contenders
      req_b = 4'b0011;
      rst_b = 1'b0;
      mh_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                 4'b0001, 4'b0001, 4'b0001};
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("maxhold_alt", gnt_b, mh_gnt[i]);
      end
      req_b = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("maxhold_lone", gnt_b, 4'b0001);
      end
      req_b = 4'b0010;
      tick(); chk("maxhold_release", gnt_b, 4'b0010);
      chk("maxhold_release_id", id_b, 2'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
